fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Responder side of the controller's fetch/branch strobes (PCWrite, InstructionRead, Branch).
- Owns the program counter and instruction register, and runs a req/ack handshake to instruction memory.
- Decodes the opcode/func3/register fields consumed by the controller and datapath.
- Computes branch targets from the latched B-type instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max REQ cycles waiting for imem_ack before a bus error (legal range 2..255).
- NOP_INSTR, 32'h0000_0013, instruction substituted on bus error (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- PCWrite  in  1  PC update strobe from controller
- InstructionRead  in  1  fetch request strobe from controller
- Branch  in  1  branch-taken qualifier, sampled with PCWrite
- imem_req  out  1  instruction memory request, held until ack or timeout
- imem_addr  out  32  word address of the request (= pc, bits[1:0]=0)
- imem_ack  in  1  memory response valid; imem_rdata is valid in the same cycle
- imem_rdata  in  32  instruction word
- instruction  out  32  instruction register
- opcode  out  7  instruction[6:0]
- func3  out  3  instruction[14:12]
- rs1, rs2, rd  out  5 each  instruction[19:15], [24:20], [11:7]
- pc  out  32  address of the next instruction to fetch
- ir_pc  out  32  address of the instruction currently in instruction
- instr_valid  out  1  one-cycle pulse when instruction is updated
- busy  out  1  high while in REQ
- bus_error  out  1  sticky, set on timeout
- misalign_err  out  1  sticky, set on misaligned branch target

Behaviour:
- Reset (async, immediate): pc=RESET_PC, ir_pc=RESET_PC, instruction=NOP_INSTR, imem_req=0, imem_addr=RESET_PC, instr_valid=0, busy=0, bus_error=0, misalign_err=0, pending redirect cleared, state=IDLE, timeout counter=0.
- Reset mid-REQ drops imem_req in the same cycle. A late imem_ack after reset is ignored.
- FSM has two states, IDLE and REQ.
- IDLE -> REQ: InstructionRead=1 at an edge.
  - Next cycle: imem_req=1, imem_addr=pc, busy=1, counter=0.
- REQ, imem_ack=1 at an edge:
  - instruction<=imem_rdata, ir_pc<=imem_addr, instr_valid=1 for the next cycle only.
  - pc<=imem_addr+4, or the pending redirect target if one is held (pending is then cleared).
  - imem_req=0, state=IDLE.
- REQ, no ack: counter increments. If counter==TIMEOUT-1 with no ack:
  - Capture NOP_INSTR, set bus_error.
  - Update pc exactly as on ack; pulse instr_valid; state=IDLE.
- Latency: InstructionRead edge to instr_valid is 2 cycles minimum (ack in the first REQ cycle). Each extra wait cycle adds 1.
- InstructionRead while in REQ is ignored; there is no queueing.
- PC update rules, evaluated at an edge in IDLE with InstructionRead=0:
  - PCWrite=1, Branch=1: target=ir_pc+immB. If target[1]=0, pc<=target. Otherwise pc is unchanged and misalign_err is set.
  - PCWrite=1, Branch=0: no change (sequential +4 was already applied at capture).
  - PCWrite=0: no change.
- PCWrite=1 together with InstructionRead=1 is a fetch cycle: only the fetch rule applies and Branch is ignored.
- PCWrite=1, Branch=1 while in REQ: target is computed from the current ir_pc/instruction and held as pending. It is applied at capture, overriding +4. A second redirect during the same REQ overwrites the pending one.
- immB = sign_extend({instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}), 13 to 32 bits.
- All PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Decode outputs are combinational from the instruction register.

Test Plan:
- Reset then InstructionRead pulse, imem_ack in the first REQ cycle with rdata=32'h00500093 -> imem_addr=0 in cycle 1, instr_valid at cycle 2, instruction=32'h00500093, opcode=7'h13, rd=1, pc=4, ir_pc=0.
- Fetch with ack delayed 5 cycles -> busy high for 6 cycles, imem_req stable, pc advances 4->8 only at capture.
- Fetch at pc=0x10 of beq with imm=-8 (32'hFE000CE3), then PCWrite=1, Branch=1 -> pc=0x08. With Branch=0 -> pc stays 0x14.
- No ack for TIMEOUT=16 cycles -> after 16 REQ cycles instruction=32'h00000013, bus_error=1 (sticky), instr_valid pulse, pc+=4.
- Branch redirect asserted during a 3-cycle wait, target 0x40 -> after capture pc=0x40, not ir_pc+4. Branch immB=6 (target bit1=1) -> misalign_err=1, pc unchanged.
- Assert rst during REQ -> imem_req=0 immediately, pc=RESET_PC; a later imem_ack causes no capture. Start pc=32'hFFFFFFFC and fetch -> pc wraps to 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns pc and the instruction register, runs the
// req/ack handshake to instruction memory, decodes the instruction fields
// and resolves B-type branch targets (immediate or deferred during a fetch).
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCWrite,
   input  logic        InstructionRead,
   input  logic        Branch,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [6:0]  opcode,
   output logic [2:0]  func3,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [31:0] pc,
   output logic [31:0] ir_pc,
   output logic        instr_valid,
   output logic        busy,
   output logic        bus_error,
   output logic        misalign_err
);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t      state;
   logic [7:0]  wait_cnt;
   logic        pend_valid;
   logic [31:0] pend_target;

   logic [31:0] imm_b;
   logic [31:0] br_target;
   logic        redirect;
   logic        br_ok;
   logic        timed_out;
   logic [31:0] next_pc;

   // Decode fields straight out of the instruction register.
   assign opcode = instruction[6:0];
   assign func3  = instruction[14:12];
   assign rs1    = instruction[19:15];
   assign rs2    = instruction[24:20];
   assign rd     = instruction[11:7];

   // Branch target from the latched instruction and the pc it was fetched from.
   always_comb begin
      imm_b     = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      br_target = ir_pc + imm_b;
      redirect  = PCWrite & Branch;
      br_ok     = ~br_target[1];
      timed_out = (wait_cnt == 8'(TIMEOUT - 1));
      // A redirect on the capture edge itself wins over an older pending one.
      if (redirect && br_ok) begin
         next_pc = br_target;
      end else if (pend_valid) begin
         next_pc = pend_target;
      end else begin
         next_pc = imem_addr + 32'd4;
      end
   end

   // Fetch FSM with pc/IR update, pending redirect and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wait_cnt     <= 8'd0;
         pend_valid   <= 1'b0;
         pend_target  <= 32'd0;
         pc           <= RESET_PC;
         ir_pc        <= RESET_PC;
         instruction  <= NOP_INSTR;
         imem_req     <= 1'b0;
         imem_addr    <= RESET_PC;
         instr_valid  <= 1'b0;
         busy         <= 1'b0;
         bus_error    <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (InstructionRead) begin
                  // Fetch takes priority; Branch is ignored on this edge.
                  state     <= REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
                  busy      <= 1'b1;
                  wait_cnt  <= 8'd0;
               end else if (redirect) begin
                  if (br_ok) begin
                     pc <= br_target;
                  end else begin
                     misalign_err <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            REQ: begin
               if (imem_ack || timed_out) begin
                  // Ack wins over a timeout landing on the same edge.
                  instruction <= imem_ack ? imem_rdata : NOP_INSTR;
                  if (!imem_ack) begin
                     bus_error <= 1'b1;
                  end else begin
                     bus_error <= bus_error;
                  end
                  if (redirect && !br_ok) begin
                     misalign_err <= 1'b1;
                  end else begin
                     misalign_err <= misalign_err;
                  end
                  ir_pc       <= imem_addr;
                  pc          <= next_pc;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  busy        <= 1'b0;
                  pend_valid  <= 1'b0;
                  wait_cnt    <= 8'd0;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (redirect) begin
                     if (br_ok) begin
                        pend_valid  <= 1'b1;
                        pend_target <= br_target;
                     end else begin
                        misalign_err <= 1'b1;
                     end
                  end else begin
                     pend_valid <= pend_valid;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a driver issues fetches/branches and
// pushes expected captures into a queue; a monitor pops them on instr_valid.
module tb_fetch_unit;

   localparam int TO = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        PCWrite = 1'b0, InstructionRead = 1'b0, Branch = 1'b0;
   logic        imem_req, imem_ack = 1'b0;
   logic [31:0] imem_addr, imem_rdata = 32'd0;
   logic [31:0] instruction, pc, ir_pc;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [4:0]  rs1, rs2, rd;
   logic        instr_valid, busy, bus_error, misalign_err;

   fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .PCWrite(PCWrite), .InstructionRead(InstructionRead),
      .Branch(Branch), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
      .opcode(opcode), .func3(func3), .rs1(rs1), .rs2(rs2), .rd(rd), .pc(pc),
      .ir_pc(ir_pc), .instr_valid(instr_valid), .busy(busy),
      .bus_error(bus_error), .misalign_err(misalign_err));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] ir_pc;
      logic [31:0] pc;
      logic        berr;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_pc = 32'd0, m_ir_pc = 32'd0, m_instr = NOP, m_pend = 32'd0;
   bit          m_berr = 1'b0, m_mis = 1'b0, m_pend_v = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // B-type immediate as a signed integer.
   function automatic int immb(input logic [31:0] i);
      int v;
      v = int'({i[31], i[7], i[30:25], i[11:8], 1'b0});
      if (i[31]) v = v - 8192;
      return v;
   endfunction

   // Build a beq with the given byte offset.
   function automatic logic [31:0] encb(input int imm);
      logic [31:0] u;
      u = imm;
      return {u[12], u[10:5], 5'd2, 5'd1, 3'd0, u[4:1], u[11], 7'h63};
   endfunction

   function automatic logic [31:0] model_target();
      return m_ir_pc + immb(m_instr);
   endfunction

   task automatic model_reset();
      m_pc = 32'd0; m_ir_pc = 32'd0; m_instr = NOP;
      m_berr = 1'b0; m_mis = 1'b0; m_pend_v = 1'b0;
      sbq.delete();
   endtask

   // monitor: compare each presented instruction against the scoreboard
   always @(negedge clk) begin
      if (!rst && instr_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr_valid: got instruction %h expected no capture", instruction);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_instruction", instruction, e.instr);
            chk("sb_ir_pc", ir_pc, e.ir_pc);
            chk("sb_pc", pc, e.pc);
            chk("sb_bus_error", bus_error, e.berr);
            chk("sb_opcode", opcode, e.instr & 32'h7F);
            chk("sb_rd", rd, (e.instr >> 7) & 32'h1F);
            chk("sb_func3", func3, (e.instr >> 12) & 32'h7);
            chk("sb_rs1", rs1, (e.instr >> 15) & 32'h1F);
            chk("sb_rs2", rs2, (e.instr >> 20) & 32'h1F);
         end
      end
   end

   // One fetch; delay>=TO means memory never answers. redir_at selects the
   // wait cycle carrying a PCWrite+Branch redirect (-1 for none).
   task automatic do_fetch(input int delay, input logic [31:0] data,
                           input int redir_at, input bit pcw_with_fetch);
      bit          tmo;
      int          nwait;
      logic [31:0] tgt;
      exp_t        e;
      tmo   = (delay >= TO);
      nwait = tmo ? TO - 1 : delay;
      @(negedge clk);
      InstructionRead = 1'b1; PCWrite = pcw_with_fetch; Branch = 1'($urandom);
      @(negedge clk);
      InstructionRead = 1'b0; PCWrite = 1'b0; Branch = 1'b0;
      chk("req_on", imem_req, 1);
      chk("req_addr", imem_addr, m_pc);
      chk("busy_on", busy, 1);
      for (int k = 0; k < nwait; k++) begin
         if (k == redir_at) begin
            PCWrite = 1'b1; Branch = 1'b1;
            tgt = model_target();
            if (tgt[1]) m_mis = 1'b1;
            else begin m_pend_v = 1'b1; m_pend = tgt; end
         end
         @(negedge clk);
         PCWrite = 1'b0; Branch = 1'b0;
         chk("wait_req", imem_req, 1);
         chk("wait_busy", busy, 1);
         chk("wait_addr", imem_addr, m_pc);
         chk("wait_pc", pc, m_pc);
         chk("wait_misalign", misalign_err, m_mis);
      end
      if (!tmo) begin
         imem_ack = 1'b1; imem_rdata = data;
      end
      e.ir_pc = m_pc;
      e.instr = tmo ? NOP : data;
      e.pc    = m_pend_v ? m_pend : m_pc + 32'd4;
      m_berr  = m_berr | tmo;
      e.berr  = m_berr;
      m_pc = e.pc; m_ir_pc = e.ir_pc; m_instr = e.instr; m_pend_v = 1'b0;
      sbq.push_back(e);
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = $urandom;
      chk("cap_valid", instr_valid, 1);
      chk("cap_busy", busy, 0);
      chk("cap_req", imem_req, 0);
      @(negedge clk);
      chk("valid_pulse", instr_valid, 0);
   endtask

   // Branch decision in IDLE.
   task automatic do_branch(input bit br);
      logic [31:0] tgt;
      @(negedge clk);
      PCWrite = 1'b1; Branch = br;
      if (br) begin
         tgt = model_target();
         if (tgt[1]) m_mis = 1'b1;
         else m_pc = tgt;
      end
      @(negedge clk);
      PCWrite = 1'b0; Branch = 1'b0;
      chk("br_pc", pc, m_pc);
      chk("br_misalign", misalign_err, m_mis);
   endtask

   task automatic check_reset_state();
      chk("rst_pc", pc, 32'h0);
      chk("rst_ir_pc", ir_pc, 32'h0);
      chk("rst_instruction", instruction, NOP);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bus_error", bus_error, 0);
      chk("rst_misalign", misalign_err, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_state();
      rst = 1'b0;

      // directed sequence
      do_fetch(0, 32'h0050_0093, -1, 1'b0);
      chk("first_pc", pc, 32'h4);
      chk("first_opcode", opcode, 32'h13);
      chk("first_rd", rd, 32'h1);
      do_fetch(5, $urandom, -1, 1'b0);
      chk("delay5_pc", pc, 32'h8);
      do_fetch(1, $urandom, -1, 1'b0);
      do_fetch(2, $urandom, -1, 1'b0);
      do_fetch(0, 32'hFE00_0CE3, -1, 1'b0);
      do_branch(1'b0);
      chk("beq_not_taken", pc, 32'h14);
      do_branch(1'b1);
      chk("beq_taken", pc, 32'h08);
      do_fetch(TO, 32'd0, -1, 1'b0);
      chk("timeout_bus_error", bus_error, 1);
      chk("timeout_pc", pc, 32'h0C);
      do_fetch(0, encb(32'h34), -1, 1'b0);
      do_fetch(3, encb(6), 1, 1'b0);
      chk("redirect_pc", pc, 32'h40);
      do_branch(1'b1);
      chk("misalign_set", misalign_err, 1);
      chk("misalign_pc", pc, 32'h40);
      chk("bus_error_sticky", bus_error, 1);

      // reset in the middle of a request
      @(negedge clk);
      InstructionRead = 1'b1;
      @(negedge clk);
      InstructionRead = 1'b0;
      chk("pre_rst_req", imem_req, 1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_reset_state();
      @(negedge clk);
      rst = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("late_ack_valid", instr_valid, 0);
      chk("late_ack_instr", instruction, NOP);
      chk("late_ack_busy", busy, 0);

      // pc wrap
      do_fetch(0, encb(-4), -1, 1'b0);
      do_branch(1'b1);
      chk("wrap_start", pc, 32'hFFFF_FFFC);
      do_fetch(1, $urandom, -1, 1'b0);
      chk("wrap_pc", pc, 32'h0);

      // randomized traffic
      for (int it = 0; it < 150; it++) begin
         int sel, dly, rat;
         sel = $urandom_range(0, 9);
         if (sel < 6) begin
            dly = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, 6);
            rat = -1;
            if (dly > 0 && dly < TO && $urandom_range(0, 2) == 0)
               rat = $urandom_range(0, dly - 1);
            do_fetch(dly, $urandom, rat, 1'($urandom_range(0, 3) == 0));
         end else if (sel < 9) begin
            do_branch(1'($urandom));
         end else begin
            @(negedge clk);
         end
      end

      repeat (3) @(negedge clk);
      chk("sb_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
